// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
// The shared MAC helper works at 64 bits; callers truncate to their own result width.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    function automatic logic [63:0] mul10_add(input logic [63:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + 64'(d);
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// Combinational x10-plus-digit step shared by every digit of a conversion.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [BIN_W-1:0] acc_o,
    output logic             digit_err_o
);

    assign acc_o       = BIN_W'(mul10_add(64'(acc_i), digit_i));
    assign digit_err_o = (digit_i > BCD_DIGIT_MAX);

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential DIGITS-digit BCD-to-binary converter: one digit per clock,
// valid/ready on both input and output sides.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   bcd_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [BIN_W-1:0]      number_o,
    output logic                  error_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SR_W  = 4 * DIGITS;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    shreg_q, shreg_d;
    logic [BIN_W-1:0]   acc_q, acc_d, mac_acc;
    logic               err_q, err_d, mac_err;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         digit;

    // Most significant remaining digit always sits in the top nibble.
    assign digit = shreg_q[SR_W-1 -: 4];

    bcd_digit_mac #(
        .BIN_W(BIN_W)
    ) u_mac (
        .acc_i       (acc_q),
        .digit_i     (digit),
        .acc_o       (mac_acc),
        .digit_err_o (mac_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shreg_d = bcd_i;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = mac_acc;
                err_d   = err_q | mac_err;
                shreg_d = shreg_q << 4;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs depend on registered state only.
    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign error_o  = valid_o & err_q;
    assign number_o = (valid_o && !err_q) ? acc_q : '0;

endmodule
